nios_system_key_debounce: RTL

Conditions one raw pushbutton before it reaches the KEY parallel-input port, which registers its 1-bit `in_port` into Avalon `readdata` bit 0. The block synchronises the asynchronous pin, rejects bounce with a stability counter and drives a clean level in the pin's native polarity, so software reading the KEY port sees no change in sense. It also emits one-cycle press/release strobes and a 16-bit press counter for the neighbouring interrupt/edge logic.

---
 rtl/nios_system_pkg.sv | 31 +++
 rtl/nios_system_sync2.sv | 28 ++
 rtl/nios_system_key_debounce.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nios_system_pkg.sv
// Shared definitions for the NIOS system PIO input conditioning blocks.
// Holds the debounce FSM encoding and the press counter width.
package nios_system_pkg;

    localparam int PRESS_CNT_W = 16;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_e;

    // A clear on the same edge as an increment leaves the counter at zero.
    function automatic logic [PRESS_CNT_W-1:0] press_count_next(
        input logic [PRESS_CNT_W-1:0] cur,
        input logic                   inc,
        input logic                   clr
    );
        logic [PRESS_CNT_W-1:0] nxt;
        if (clr) begin
            nxt = {PRESS_CNT_W{1'b0}};
        end else if (inc) begin
            nxt = cur + {{(PRESS_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/nios_system_sync2.sv
// Two-flop synchroniser for an asynchronous PIO input pin.
// The reset value lets each input power up in its idle sense.
module nios_system_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_r <= RESET_VAL;
            q_r    <= RESET_VAL;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/nios_system_key_debounce.sv
// Pushbutton conditioner for the KEY PIO: synchronise, debounce with a
// stability counter, and emit a clean level, press/release strobes and a press count.
module nios_system_key_debounce
    import nios_system_pkg::*;
#(
    parameter int STABLE_CYCLES = 50000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   key_raw,
    input  logic                   clr_count,
    output logic                   key_level,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic [PRESS_CNT_W-1:0] press_count
);

    localparam int              CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                   sync_s;
    logic                   pressed_s;
    key_state_e             state_r;
    key_state_e             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   press_acc_s;
    logic                   release_acc_s;
    logic                   key_level_r;
    logic                   press_pulse_r;
    logic                   release_pulse_r;
    logic [PRESS_CNT_W-1:0] press_count_r;

    nios_system_sync2 #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (key_raw),
        .q       (sync_s)
    );

    // Normalise to "button is pressed" regardless of board wiring.
    assign pressed_s = sync_s ^ ACTIVE_LOW;

    // FSM state and qualification counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= RELEASED;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: a level must survive the whole count, any reversal restarts.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_acc_s   = 1'b0;
        release_acc_s = 1'b0;
        case (state_r)
            RELEASED: begin
                if (pressed_s) begin
                    state_nxt_s = PRESS_PEND;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = RELEASED;
                end
            end
            PRESS_PEND: begin
                if (!pressed_s) begin
                    state_nxt_s = RELEASED;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = PRESSED;
                    press_acc_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_nxt_s = RELEASE_PEND;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            RELEASE_PEND: begin
                if (pressed_s) begin
                    state_nxt_s = PRESSED;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = RELEASED;
                    release_acc_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = RELEASED;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Registered outputs: level in pin polarity, one-cycle strobes, press counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_level_r     <= ACTIVE_LOW;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
            press_count_r   <= {PRESS_CNT_W{1'b0}};
        end else begin
            press_pulse_r   <= press_acc_s;
            release_pulse_r <= release_acc_s;
            press_count_r   <= press_count_next(press_count_r, press_acc_s, clr_count);
            if (press_acc_s) begin
                key_level_r <= ~ACTIVE_LOW;
            end else if (release_acc_s) begin
                key_level_r <= ACTIVE_LOW;
            end else begin
                key_level_r <= key_level_r;
            end
        end
    end

    assign key_level     = key_level_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;
    assign press_count   = press_count_r;

endmodule
